// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I pipeline.
// Fetch-side entries pair each instruction word with the PC it was fetched from.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty & ~clear;
  assign w_do_push = push & (~full | w_do_pop) & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: issues word fetches to a req/gnt/rvalid
// memory, buffers returns in order, and squashes in-flight words on redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      r_pc_f;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pc_d;
  logic [31:0]      r_pcplus4_d;
  logic             r_valid_d;

  logic             w_issue;
  logic             w_keep;
  logic             w_pop_ifid;
  logic [CNT_W-1:0] w_out_after_resp;
  logic [SUM_W-1:0] w_in_use;
  logic [31:0]      w_pcq_head;
  logic [CNT_W-1:0] w_pcq_count;
  logic             w_pcq_full;
  logic             w_pcq_empty;
  fetch_entry_t     w_fifo_in;
  fetch_entry_t     w_fifo_head;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_unused;

  // Buffered responses count against the cap so a stalled decode cannot overflow the FIFO.
  assign w_in_use         = SUM_W'(r_outstanding) + SUM_W'(w_fifo_count);
  assign imem_req         = ~reset & ~redirect & (w_in_use < SUM_W'(MAX_OUTSTANDING));
  assign imem_addr        = r_pc_f;
  assign w_issue          = imem_req & imem_gnt;
  assign w_out_after_resp = r_outstanding - CNT_W'(imem_rvalid);
  assign w_keep           = imem_rvalid & ~redirect & (r_discard == '0);
  assign w_pop_ifid       = ~flush_d & ~stall_d & ~redirect & ~w_fifo_empty;
  assign w_fifo_in        = '{pc: w_pcq_head, instr: imem_rdata};
  assign w_unused         = ^{w_pcq_count, w_pcq_full, w_pcq_empty, w_fifo_full,
                              redirect_pc[1:0]};

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_issue),
    .push_data (r_pc_f),
    .pop       (imem_rvalid),
    .pop_data  (w_pcq_head),
    .clear     (1'b0),
    .full      (w_pcq_full),
    .empty     (w_pcq_empty),
    .count     (w_pcq_count)
  );

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_keep),
    .push_data (w_fifo_in),
    .pop       (w_pop_ifid),
    .pop_data  (w_fifo_head),
    .clear     (redirect),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f        <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_after_resp + CNT_W'(w_issue);
      if (redirect) begin
        r_pc_f    <= {redirect_pc[31:2], 2'b00};
        r_discard <= w_out_after_resp;
      end else begin
        if (w_issue) r_pc_f <= pc_plus4(r_pc_f);
        if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (flush_d) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (!stall_d) begin
      if (w_pop_ifid) begin
        r_instr_d   <= w_fifo_head.instr;
        r_pc_d      <= w_fifo_head.pc;
        r_pcplus4_d <= pc_plus4(w_fifo_head.pc);
        r_valid_d   <= 1'b1;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign pcplus4_d = r_pcplus4_d;
  assign valid_d   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: an in-order variable-latency memory model
// feeds the DUT while a monitor checks the IF/ID stream against the program order.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int unsigned MaxOut  = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          NCyc    = 3000;
  localparam int          RstAt   = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC        (ResetPc),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d)
  );

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_req_t;

  mem_req_t    mem_q[$];   // accepted, not yet answered, in request order
  logic [31:0] exp_q[$];   // program-order PCs decode should see next
  logic [31:0] stream_pc;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_retired = 0;
  int          cyc;
  int          gnt_hold;
  logic        acc, rsp, redir, addr_chk;
  logic [31:0] acc_addr, redir_tgt;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) + {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_pc);
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},     {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"},   {31'd0, valid_d},  32'd0);
    check({tag, "_instr"},   instr_d,           NOP_INSTR);
    check({tag, "_pc"},      pc_d,              32'd0);
    check({tag, "_pcplus4"}, pcplus4_d,         32'd0);
  endtask

  task automatic drive_cycle(input int i);
    logic directed;
    directed = (cyc < 8);
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (directed) begin
      imem_gnt = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0;
    end else if (i >= RstAt - 8 && i < RstAt) begin
      imem_gnt = 1'b1; stall_d = 1'b1; flush_d = 1'b0; redirect = 1'b0;
    end else begin
      if (gnt_hold > 0) begin
        imem_gnt = 1'b0;
        gnt_hold--;
      end else begin
        imem_gnt = ($urandom_range(0, 3) != 0);
      end
      stall_d  = ($urandom_range(0, 99) < 15);
      flush_d  = ($urandom_range(0, 99) < 3);
      redirect = ($urandom_range(0, 99) < 5);
      if (redirect) begin
        flush_d = 1'b1;
        case ($urandom_range(0, 2))
          0:       redirect_pc = 32'h0000_0103;
          1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: redirect_pc = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) gnt_hold = 3;
      end
    end
  endtask

  // Monitor: every fresh valid IF/ID entry must be the next program-order PC.
  initial begin : monitor
    logic        l_stall, l_flush, p_valid;
    logic [31:0] p_pc, p_instr, p_p4, e;
    l_stall = 1'b0; l_flush = 1'b0; p_valid = 1'b0;
    p_pc = '0; p_instr = '0; p_p4 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        l_stall = 1'b0;
        l_flush = 1'b0;
      end else begin
        if (l_flush) begin
          check("flush_valid", {31'd0, valid_d}, 32'd0);
          check("flush_instr", instr_d, NOP_INSTR);
        end else if (l_stall) begin
          check("stall_pc",    pc_d,      p_pc);
          check("stall_instr", instr_d,   p_instr);
          check("stall_p4",    pcplus4_d, p_p4);
          check("stall_valid", {31'd0, valid_d}, {31'd0, p_valid});
        end else if (valid_d) begin
          if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc",      pc_d,      e);
            check("ifid_instr",   instr_d,   word_at(e));
            check("ifid_pcplus4", pcplus4_d, e + 32'd4);
            n_retired++;
          end
        end else begin
          check("bubble_instr", instr_d, NOP_INSTR);
        end
        p_pc = pc_d; p_instr = instr_d; p_p4 = pcplus4_d; p_valid = valid_d;
        l_stall = stall_d;
        l_flush = flush_d;
      end
    end
  end

  initial begin : driver
    int lat;
    reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    gnt_hold = 0; addr_chk = 1'b0;
    #1;
    check_reset_vals("reset0");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    stream_pc = ResetPc;
    top_up();
    drive_cycle(0);
    for (int i = 0; i < NCyc; i++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr,         ResetPc);
      end
      if (cyc < 3) check("early_valid", {31'd0, valid_d}, 32'd0);
      if (cyc == 3) check("valid_at_3", {31'd0, valid_d}, 32'd1);
      if (redirect) check("req_in_redirect", {31'd0, imem_req}, 32'd0);
      if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (addr_chk) check("redirect_addr", imem_addr, redir_tgt);
      check("outstanding_cap", {31'd0, (mem_q.size() <= MaxOut)}, 32'd1);
      acc       = imem_req & imem_gnt;
      acc_addr  = imem_addr;
      rsp       = imem_rvalid;
      redir     = redirect;
      if (redirect) redir_tgt = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      #1;
      if (i == RstAt) begin
        #2 reset = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        mem_q.delete();
        exp_q.delete();
        stream_pc = ResetPc;
        imem_rvalid = 1'b0; imem_gnt = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        redirect = 1'b0; gnt_hold = 0; addr_chk = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        top_up();
        drive_cycle(i);
      end else begin
        if (rsp) void'(mem_q.pop_front());
        if (acc) begin
          lat = (cyc < 8) ? 1 : $urandom_range(1, 3);
          mem_q.push_back('{addr: acc_addr, ready: cyc + lat});
        end
        cyc++;
        addr_chk = redir;
        if (redir) begin
          exp_q.delete();
          stream_pc = redir_tgt;
        end
        top_up();
        drive_cycle(i);
      end
    end
    check("retired_min", {31'd0, (n_retired > 100)}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
